// File: rtl/conv_pe_pkg.sv
// conv_pe_pkg: shared FSM state type, default parameters and the saturation helper
package conv_pe_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_t;
  localparam int DW_DEF        = 8;
  localparam int FDEPTH_DEF    = 16;
  localparam int NCH_DEF       = 4;
  localparam int OFM_DEPTH_DEF = 256;
  localparam int SHIFT_DEF     = 0;
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    return (v > hi) ? hi : (v < -hi - 64'sd1) ? -hi - 64'sd1 : v;
  endfunction
endpackage

// File: rtl/conv_pe_mac.sv
// conv_pe_mac: signed multiply-accumulate with quantise/saturate; CONV_PE_RELU_EN clamps negatives to 0
module conv_pe_mac import conv_pe_pkg::*; #(
  parameter int DW    = DW_DEF,
  parameter int KW    = 4,
  parameter int SHIFT = SHIFT_DEF,
  localparam int ACCW = 2 * DW + KW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          beat_i,
  input  logic          first_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] res_o,
  output logic          sat_o
);
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_x, acc_q, acc_d, relu, shifted;
  logic signed [63:0]     wide, q;
  assign prod   = $signed({{DW{a_i[DW-1]}}, a_i} * {{DW{b_i[DW-1]}}, b_i});
  assign prod_x = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
  // next accumulator value and its quantised form, used on the last beat of a pixel
  always_comb begin
    acc_d = first_i ? prod_x : acc_q + prod_x;
`ifdef CONV_PE_RELU_EN
    relu = acc_d[ACCW-1] ? '0 : acc_d;
`else
    relu = acc_d;
`endif
    shifted = relu >>> SHIFT;
    wide = {{(64-ACCW){shifted[ACCW-1]}}, shifted};
    q = saturate(wide, DW);
    res_o = q[DW-1:0];
    sat_o = q != wide;
  end
  // accumulator advances only on accepted beats so stream gaps stall cleanly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else if (beat_i) acc_q <= acc_d;
  end
endmodule

// File: rtl/conv_pe.sv
// conv_pe: 1-D convolution PE packing NCH results per OFM word; CONV_PE_RELU_EN enables ReLU in the MAC
module conv_pe import conv_pe_pkg::*; #(
  parameter int DW        = DW_DEF,
  parameter int FDEPTH    = FDEPTH_DEF,
  parameter int NCH       = NCH_DEF,
  parameter int OFM_DEPTH = OFM_DEPTH_DEF,
  parameter int SHIFT     = SHIFT_DEF,
  localparam int KW = $clog2(FDEPTH),
  localparam int AW = $clog2(OFM_DEPTH),
  localparam int CW = $clog2(NCH),
  localparam int NW = AW + CW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KW-1:0]     cfg_k,
  input  logic [NW-1:0]     cfg_nout,
  input  logic              flt_we,
  input  logic [KW-1:0]     flt_addr,
  input  logic [DW-1:0]     flt_wdata,
  input  logic              if_valid,
  input  logic [DW-1:0]     if_data,
  output logic              if_ready,
  input  logic [AW-1:0]     ofm_rd_addr,
  output logic [NCH*DW-1:0] ofm_rd_data,
  output logic              busy,
  output logic              done,
  output logic              sat_flag
);
  state_t                 state_q, state_d;
  logic [KW-1:0]          kcfg_q, k_q;
  logic [NW-1:0]          nout_q, pix_q;
  logic [CW-1:0]          lane_q;
  logic [AW-1:0]          wr_addr_q;
  logic [NCH-1:0][DW-1:0] sr_q;
  logic                   sat_q;
  logic [NCH*DW-1:0]      rd_q;
  logic [DW-1:0]          flt_mem [FDEPTH];
  logic [NCH*DW-1:0]      ofm_mem [OFM_DEPTH];
  logic                   beat, last_k, last_px, grp_done, res_sat;
  logic [DW-1:0]          res;
  assign beat        = if_valid && if_ready;
  assign last_k      = k_q == kcfg_q;
  assign last_px     = pix_q + NW'(1) == nout_q;
  assign grp_done    = beat && last_k && (lane_q == CW'(NCH - 1) || last_px);
  assign busy        = state_q != S_IDLE;
  assign if_ready    = state_q == S_RUN;
  assign done        = state_q == S_DONE;
  assign sat_flag    = sat_q;
  assign ofm_rd_data = rd_q;
  conv_pe_mac #(.DW(DW), .KW(KW), .SHIFT(SHIFT)) u_mac (
    .clk(clk), .rst_n(rst_n), .beat_i(beat), .first_i(k_q == '0),
    .a_i(if_data), .b_i(flt_mem[k_q]), .res_o(res), .sat_o(res_sat)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  // next-state: run pixels, flush each full or final group, then pulse done
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_RUN : S_IDLE;
      S_RUN:   state_d = grp_done ? S_WRITE : S_RUN;
      S_WRITE: state_d = pix_q == nout_q ? S_DONE : S_RUN;
      default: state_d = S_IDLE;
    endcase
  end
  // run counters, lane shift register and sticky saturation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcfg_q <= '0; k_q <= '0; nout_q <= '0; pix_q <= '0;
      lane_q <= '0; wr_addr_q <= '0; sr_q <= '0; sat_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        kcfg_q <= cfg_k; nout_q <= cfg_nout; k_q <= '0; pix_q <= '0;
        lane_q <= '0; wr_addr_q <= '0; sr_q <= '0; sat_q <= 1'b0;
      end
      if (beat) begin
        k_q <= last_k ? '0 : k_q + 1'b1;
        if (last_k) begin
          sr_q[lane_q] <= res;
          lane_q <= lane_q + 1'b1;
          pix_q <= pix_q + 1'b1;
          if (res_sat) sat_q <= 1'b1;
        end
      end
      if (state_q == S_WRITE) begin
        wr_addr_q <= wr_addr_q + 1'b1;
        lane_q <= '0;
        sr_q <= '0;
      end
    end
  end
  // filter buffer is writable only while idle
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && flt_we) flt_mem[flt_addr] <= flt_wdata;
  end
  // OFM array write; cleared lanes make partial groups zero-filled
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE) ofm_mem[wr_addr_q] <= sr_q;
  end
  // registered read port returns pre-write data on a same-cycle collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else rd_q <= ofm_mem[ofm_rd_addr];
  end
endmodule

// File: tb/tb_conv_pe.sv
// tb_conv_pe: directed and randomized checks of conv_pe against a convolution reference model
module tb_conv_pe;
  localparam int DW = 8, FDEPTH = 16, NCH = 4, OFM_DEPTH = 256, SHIFT = 0, KW = 4, AW = 8;
  logic              clk = 0, rst_n = 0, start = 0;
  logic [KW-1:0]     cfg_k = '0;
  logic [AW+1:0]     cfg_nout = '0;
  logic              flt_we = 0;
  logic [KW-1:0]     flt_addr = '0;
  logic [DW-1:0]     flt_wdata = '0;
  logic              if_valid = 0;
  logic [DW-1:0]     if_data = '0;
  logic              if_ready, busy, done, sat_flag;
  logic [AW-1:0]     ofm_rd_addr = '0;
  logic [NCH*DW-1:0] ofm_rd_data;
  int vectors = 0, miscompares = 0;
  int fm[FDEPTH];
  int xs[$];
  int done_cnt, done_lag;
  logic sat_at_start;

  always #5 clk = ~clk;

  conv_pe #(.DW(DW), .FDEPTH(FDEPTH), .NCH(NCH), .OFM_DEPTH(OFM_DEPTH), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_nout(cfg_nout),
    .flt_we(flt_we), .flt_addr(flt_addr), .flt_wdata(flt_wdata),
    .if_valid(if_valid), .if_data(if_data), .if_ready(if_ready),
    .ofm_rd_addr(ofm_rd_addr), .ofm_rd_data(ofm_rd_data),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_px(input int p, input int k, output bit s);
    longint a = 0;
    for (int j = 0; j < k; j++) a += longint'(xs[p*k+j]) * longint'(fm[j]);
`ifdef CONV_PE_RELU_EN
    if (a < 0) a = 0;
`endif
    a = a >>> SHIFT;
    s = (a > 127) || (a < -128);
    return (a > 127) ? 127 : (a < -128) ? -128 : int'(a);
  endfunction

  task automatic wr_flt();
    for (int i = 0; i < FDEPTH; i++) begin
      @(negedge clk); flt_we = 1; flt_addr = KW'(i); flt_wdata = 8'(fm[i]);
    end
    @(negedge clk); flt_we = 0;
  endtask

  task automatic run(input int k, input int nout, input bit gaps, input bit extra);
    int idx = 0, n = k * nout, cyc = 0, last_cyc = -1, post = 0;
    done_cnt = 0; done_lag = -1;
    @(negedge clk); start = 1; cfg_k = KW'(k - 1); cfg_nout = (AW+2)'(nout);
    @(negedge clk); start = 0; sat_at_start = sat_flag;
    while (post <= 3 && cyc < 3000) begin
      if (done) begin
        done_cnt++;
        if (done_lag < 0) done_lag = cyc - last_cyc;
      end
      if (done_cnt > 0) post++;
      if (idx < n) begin
        if_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if_data = 8'(xs[idx]);
        if (if_valid && if_ready) begin
          idx++;
          if (idx == n) last_cyc = cyc;
        end
      end else if_valid = 0;
      start = extra && cyc == 7;
      if (start) begin cfg_k = '0; cfg_nout = 1; end
      flt_we = gaps && busy; flt_addr = KW'($urandom); flt_wdata = 8'($urandom);
      @(negedge clk); cyc++;
    end
    if_valid = 0; start = 0; flt_we = 0;
    chk("done_count", 64'(done_cnt), 64'd1);
  endtask

  task automatic check_ofm(input int k, input int nout, input string tag);
    logic [31:0] exp;
    bit s, sany;
    int v;
    sany = 0;
    for (int w = 0; w < (nout + 3) / 4; w++) begin
      exp = '0;
      for (int l = 0; l < 4; l++) if (w*4 + l < nout) begin
        v = model_px(w*4 + l, k, s);
        sany |= s;
        exp[l*8 +: 8] = 8'(v);
      end
      @(negedge clk) ofm_rd_addr = AW'(w);
      @(negedge clk);
      chk($sformatf("%s_ofm%0d", tag, w), 64'(ofm_rd_data), 64'(exp));
    end
    chk({tag, "_sat"}, 64'(sat_flag), 64'(sany));
  endtask

  task automatic rd_chk(input int a, input logic [31:0] exp, input string tag);
    @(negedge clk) ofm_rd_addr = AW'(a);
    @(negedge clk);
    chk(tag, 64'(ofm_rd_data), 64'(exp));
  endtask

  initial begin
    int k, nout, dc;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(if_ready), 64'd0);
    chk("rst_sat", 64'(sat_flag), 64'd0);
    chk("rst_rd", 64'(ofm_rd_data), 64'd0);
    rst_n = 1;
    // all-ones filter, K=4, four pixels of 1,2,3,4
    foreach (fm[i]) fm[i] = 1;
    wr_flt();
    xs = {};
    for (int p = 0; p < 4; p++) for (int j = 1; j <= 4; j++) xs.push_back(j);
    run(4, 4, 0, 0);
    chk("t1_done_lag", 64'(done_lag), 64'd2);
    rd_chk(0, 32'h0a0a0a0a, "t1_const");
    check_ofm(4, 4, "t1");
    // saturation
    foreach (fm[i]) fm[i] = 127;
    wr_flt();
    xs = {};
    for (int j = 0; j < 16; j++) xs.push_back(127);
    run(16, 1, 0, 0);
    rd_chk(0, 32'h0000007f, "t2_const");
    chk("t2_sat_flag", 64'(sat_flag), 64'd1);
    check_ofm(16, 1, "t2");
    // negative input, sat cleared by the new start
    foreach (fm[i]) fm[i] = 1;
    wr_flt();
    xs = {-5};
    run(1, 1, 0, 0);
    chk("t3_sat_clear", 64'(sat_at_start), 64'd0);
`ifdef CONV_PE_RELU_EN
    rd_chk(0, 32'h00000000, "t3_const");
`else
    rd_chk(0, 32'h000000fb, "t3_const");
`endif
    check_ofm(1, 1, "t3");
    // partial last group
    xs = {1, 2, 3, 4, 5};
    run(1, 5, 0, 0);
    rd_chk(0, 32'h04030201, "t4_w0");
    rd_chk(1, 32'h00000005, "t4_w1");
    check_ofm(1, 5, "t4");
    // random filters/data: gapped run with a stray start, then gap-free run
    for (int it = 0; it < 3; it++) begin
      foreach (fm[i]) fm[i] = int'($urandom_range(0, 255)) - 128;
      wr_flt();
      k = $urandom_range(3, 16);
      nout = $urandom_range(3, 9);
      xs = {};
      for (int j = 0; j < k * nout; j++) xs.push_back(int'($urandom_range(0, 255)) - 128);
      run(k, nout, 1, 1);
      check_ofm(k, nout, $sformatf("rnd%0d_gap", it));
      run(k, nout, 0, 0);
      check_ofm(k, nout, $sformatf("rnd%0d_flat", it));
    end
    // reset in the middle of a run
    xs = {};
    for (int j = 0; j < 16; j++) xs.push_back(int'($urandom_range(0, 255)) - 128);
    @(negedge clk); start = 1; cfg_k = 3; cfg_nout = 4;
    @(negedge clk); start = 0;
    for (int j = 0; j < 5; j++) begin
      if_valid = 1; if_data = 8'(xs[j]);
      @(negedge clk);
    end
    rst_n = 0; if_valid = 0;
    #1;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_ready", 64'(if_ready), 64'd0);
    dc = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("mr_no_done", 64'(dc), 64'd0);
    rst_n = 1;
    run(4, 4, 0, 0);
    check_ofm(4, 4, "mr_after");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
